// File: rtl/wb_trace_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_trace_buffer                                               |
// | Brief    : FIFO trace capture of core write-back words, optional repeat  |
// |            filter, valid/ready drain, saturating overflow drop counter.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wb_trace_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [WIDTH-1:0]           wb_data,
    input  logic                       filter_en,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           drop_cnt
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [WIDTH-1:0] r_last_word;
    logic             r_has_last;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [c_PW-1:0]  w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_cand;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Pointer difference modulo 2^c_PW is the occupancy; the extra MSB separates full from empty.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_level == c_PW'(DEPTH));

    assign w_cand  = wb_valid && !(filter_en && r_has_last && (wb_data == r_last_word));
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = w_cand && (!w_full || w_pop);
    assign w_drop  = w_cand && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_last_word <= '0;
            r_has_last  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + c_PW'(1);
                r_last_word <= wb_data;
                r_has_last  <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wb_data;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign level     = w_level;
    assign full      = w_full;
    assign empty     = w_empty;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wb_trace_buffer                                            |
// | Brief    : Directed self-checking bench for wb_trace_buffer.             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wb_trace_buffer;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        filter_en;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    wb_trace_buffer #(.WIDTH(32), .DEPTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_data(wb_data),
        .filter_en(filter_en), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .level(level), .full(full), .empty(empty),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        wb_valid = 1'b1;
        wb_data  = d;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: empty=%b full=%b expected 1/0", empty, full); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(exp_w[i]);
        n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL basic_level: got %0d expected 3", level); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin n_fail++; $display("FAIL basic_drain%0d: got v=%b %h expected v=1 %h", i, out_valid, out_data, exp_w[i]); end
            step();
        end
        n_checks++; if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0) begin n_fail++; $display("FAIL basic_empty: empty=%b v=%b data=%h expected 1/0/0", empty, out_valid, out_data); end
        out_ready = 1'b0;
    endtask

    task automatic test_no_bypass();
        wb_valid = 1'b1; wb_data = 32'h55; out_ready = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_same_cycle: got v=%b expected 0", out_valid); end
        step();
        wb_valid = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin n_fail++; $display("FAIL bypass_next_cycle: got v=%b %h expected v=1 55", out_valid, out_data); end
        step();
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL bypass_drained: got empty=%b expected 1", empty); end
    endtask

    task automatic test_filter();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hA; exp_w[1] = 32'hB; exp_w[2] = 32'hA;
        filter_en = 1'b1;
        push(32'hA); push(32'hA); push(32'hB); push(32'hA);
        filter_en = 1'b0;
        n_checks++; if (level !== 4'd3) begin n_fail++; $display("FAIL filter_level: got %0d expected 3", level); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL filter_drop_cnt: got %0d expected 0", drop_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (out_data !== exp_w[i]) begin n_fail++; $display("FAIL filter_drain%0d: got %h expected %h", i, out_data, exp_w[i]); end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
        n_checks++; if (full !== 1'b1 || level !== 4'd8) begin n_fail++; $display("FAIL ovf_full: full=%b level=%0d expected 1/8", full, level); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (out_data !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL ovf_drain%0d: got %h expected %h", i, out_data, 32'h100 + 32'(i)); end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_push_pop();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h200 + 32'(i));
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b expected 1", full); end
        n_checks++; if (out_data !== 32'h200) begin n_fail++; $display("FAIL fpp_head: got %h expected 200", out_data); end
        out_ready = 1'b1;
        push(32'h2FF);
        out_ready = 1'b0;
        n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL fpp_level: got %0d expected 8", level); end
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL fpp_drop_cnt: got %0d expected 2", drop_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] exp_d;
            exp_d = (i < 7) ? 32'h201 + 32'(i) : 32'h2FF;
            n_checks++; if (out_data !== exp_d) begin n_fail++; $display("FAIL fpp_drain%0d: got %h expected %h", i, out_data, exp_d); end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] q[$];
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic rdy = 1'b1;
        logic [31:0] held;
        logic stalled;
        while (recv < 20 && cyc < 200) begin
            wb_valid  = (sent < 20) && (q.size() < 8);
            wb_data   = 32'h300 + 32'(sent);
            out_ready = rdy;
            #1;
            stalled = 1'b0;
            if (q.size() > 0) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== q[0]) begin n_fail++; $display("FAIL stream_word%0d: got v=%b %h expected v=1 %h", recv, out_valid, out_data, q[0]); end
                if (rdy) begin
                    void'(q.pop_front());
                    recv++;
                end else begin
                    stalled = 1'b1;
                    held = q[0];
                end
            end
            if (wb_valid) begin
                q.push_back(wb_data);
                sent++;
            end
            @(posedge clk);
            #1;
            if (stalled) begin
                n_checks++; if (out_data !== held) begin n_fail++; $display("FAIL stream_stall: got %h expected %h", out_data, held); end
            end
            rdy = ~rdy;
            cyc++;
        end
        wb_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (recv != 20) begin n_fail++; $display("FAIL stream_count: got %0d expected 20 (cycle budget)", recv); end
        n_checks++; if (drop_cnt !== 16'd2 || empty !== 1'b1) begin n_fail++; $display("FAIL stream_end: drop=%0d empty=%b expected 2/1", drop_cnt, empty); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        filter_en = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h4A7 + 32'(i));
        n_checks++; if (level !== 4'd5) begin n_fail++; $display("FAIL rstmid_pre_level: got %0d expected 5", level); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (level !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: level=%0d v=%b expected 0/0", level, out_valid); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop_cnt: got %0d expected 0", drop_cnt); end
        step();
        #2;
        rst = 1'b0;
        step();
        filter_en = 1'b1;
        push(32'h4AB);
        n_checks++; if (level !== 4'd1 || out_data !== 32'h4AB) begin n_fail++; $display("FAIL rstmid_first_word: level=%0d data=%h expected 1/4ab", level, out_data); end
        push(32'h4AB);
        n_checks++; if (level !== 4'd1 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_filtered: level=%0d drop=%0d expected 1/0", level, drop_cnt); end
        filter_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_data = '0; filter_en = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_no_bypass();
        test_filter();
        test_overflow();
        test_full_push_pop();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
